tennis_rally_ctrl: RTL and testbench

// Two-player LED tennis game controller. Consumes the one-cycle PB_down pulses from two

---
 rtl/tennis_rally_ctrl_pkg.sv | 13 +
 rtl/tennis_rally_ctrl_tick_gen.sv | 18 +
 rtl/tennis_rally_ctrl.sv | 173 +++++++++++++++++
 tb/tb_tennis_rally_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tennis_rally_ctrl_pkg.sv
// tennis_rally_ctrl_pkg: shared FSM state encoding and player identifiers for the rally controller
package tennis_rally_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_MOVE_R = 3'd2,
    ST_MOVE_L = 3'd3,
    ST_POINT  = 3'd4,
    ST_OVER   = 3'd5
  } state_e;
  localparam logic PLAYER_P1 = 1'b0;
  localparam logic PLAYER_P2 = 1'b1;
endpackage

// File: rtl/tennis_rally_ctrl_tick_gen.sv
// tennis_rally_ctrl_tick_gen: free-running 0..period-1 counter with clear, one-cycle tick at the top
module tennis_rally_ctrl_tick_gen #(
  parameter int W = 25
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic [W-1:0] period_i,
  output logic         tick_o
);
  logic [W-1:0] cnt_q;
  // >= rather than == so a shortened period never lets the count run past its end
  assign tick_o = cnt_q >= period_i - 1'b1;
  // count up, wrap on tick, restart from zero whenever the controller re-arms the step timer
  always_ff @(posedge clk_i)
    if (reset_i || clr_i) cnt_q <= '0;
    else cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/tennis_rally_ctrl.sv
// tennis_rally_ctrl: two-player LED tennis FSM sequencing serve, ball travel, hit judging, scoring and game-over
module tennis_rally_ctrl
  import tennis_rally_ctrl_pkg::*;
#(
  parameter int NUM_LEDS   = 16,
  parameter int HIT_WINDOW = 2,
  parameter int TICK_INIT  = 25_000_000,
  parameter int TICK_STEP  = 2_500_000,
  parameter int TICK_MIN   = 5_000_000,
  parameter int POINT_HOLD = 4,
  parameter int WIN_SCORE  = 7,
  parameter int SCORE_W    = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                p1_hit_i,
  input  logic                p2_hit_i,
  output logic [NUM_LEDS-1:0] ball_pos_o,
  output logic [SCORE_W-1:0]  p1_score_o,
  output logic [SCORE_W-1:0]  p2_score_o,
  output logic                point_p1_o,
  output logic                point_p2_o,
  output logic                game_over_o,
  output logic                winner_o
);
  localparam int PW = $clog2(NUM_LEDS);
  localparam int TW = $clog2(TICK_INIT + 1);
  localparam int HW = $clog2(POINT_HOLD + 1);
  localparam logic [PW-1:0] LAST   = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0] WIN_R  = PW'(NUM_LEDS - HIT_WINDOW);
  localparam logic [PW-1:0] WIN_L  = PW'(HIT_WINDOW);
  localparam logic [TW-1:0] T_INIT = TW'(TICK_INIT);
  localparam logic [TW-1:0] T_STEP = TW'(TICK_STEP);
  localparam logic [TW-1:0] T_MIN  = TW'(TICK_MIN);
  localparam logic [TW-1:0] T_THR  = TW'(TICK_MIN + TICK_STEP);
  localparam logic [HW-1:0] H_LAST = HW'(POINT_HOLD - 1);
  localparam logic [SCORE_W-1:0] S_WIN = SCORE_W'(WIN_SCORE);

  state_e               state_q, state_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic [TW-1:0]        period_q, period_d, faster;
  logic [HW-1:0]        hold_q, hold_d;
  logic [SCORE_W-1:0]   s1_q, s1_d, s2_q, s2_d;
  logic                 server_q, server_d, last_q, last_d, winner_q, winner_d;
  logic                 pt1_q, pt2_q, over_q;
  logic [NUM_LEDS-1:0]  ball_q, ball_d;
  logic                 tick, clr, award, award_to;
  logic                 going_r, rx_hit, in_window, at_end;

  tennis_rally_ctrl_tick_gen #(.W(TW)) u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (clr),
    .period_i(period_q),
    .tick_o  (tick)
  );

  // only the receiving player's button matters while the ball is in flight
  assign going_r   = state_q == ST_MOVE_R;
  assign rx_hit    = going_r ? p2_hit_i : p1_hit_i;
  assign in_window = going_r ? pos_q >= WIN_R : pos_q < WIN_L;
  assign at_end    = pos_q == (going_r ? LAST : '0);
  assign faster    = period_q >= T_THR ? period_q - T_STEP : T_MIN;
  assign ball_d    = state_d == ST_IDLE ? '0 : NUM_LEDS'(1) << pos_d;

  // next-state logic: a hit outranks a coincident tick, and any lost rally funnels into one award path
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    period_d = period_q;
    hold_d   = hold_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    server_d = server_q;
    last_d   = last_q;
    winner_d = winner_q;
    clr      = 1'b0;
    award    = 1'b0;
    award_to = PLAYER_P1;
    case (state_q)
      ST_IDLE, ST_OVER: if (start_i) begin
        state_d  = ST_SERVE;
        server_d = PLAYER_P1;
        pos_d    = '0;
        s1_d     = '0;
        s2_d     = '0;
      end
      ST_SERVE: begin
        period_d = T_INIT;
        if (server_q == PLAYER_P1 ? p1_hit_i : p2_hit_i) begin
          state_d = server_q == PLAYER_P1 ? ST_MOVE_R : ST_MOVE_L;
          clr     = 1'b1;
        end
      end
      ST_MOVE_R, ST_MOVE_L: begin
        award_to = going_r ? PLAYER_P1 : PLAYER_P2;
        if (rx_hit) begin
          if (in_window) begin
            state_d  = going_r ? ST_MOVE_L : ST_MOVE_R;
            period_d = faster;
            clr      = 1'b1;
          end else award = 1'b1;
        end else if (tick) begin
          if (at_end) award = 1'b1;
          else pos_d = going_r ? pos_q + 1'b1 : pos_q - 1'b1;
        end
      end
      ST_POINT: if (tick) begin
        if (hold_q == H_LAST) begin
          hold_d = '0;
          if ((last_q == PLAYER_P1 ? s1_q : s2_q) == S_WIN) begin
            state_d  = ST_OVER;
            winner_d = last_q;
          end else begin
            state_d  = ST_SERVE;
            server_d = last_q;
            pos_d    = last_q == PLAYER_P1 ? '0 : LAST;
          end
        end else hold_d = hold_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (award) begin
      state_d = ST_POINT;
      clr     = 1'b1;
      hold_d  = '0;
      last_d  = award_to;
      s1_d    = award_to == PLAYER_P1 ? s1_q + 1'b1 : s1_q;
      s2_d    = award_to == PLAYER_P2 ? s2_q + 1'b1 : s2_q;
    end
  end

  // all state and every output are registered so the display drivers see glitch-free values
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_q  <= ST_IDLE;
      pos_q    <= '0;
      period_q <= T_INIT;
      hold_q   <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      server_q <= PLAYER_P1;
      last_q   <= PLAYER_P1;
      winner_q <= PLAYER_P1;
      pt1_q    <= 1'b0;
      pt2_q    <= 1'b0;
      over_q   <= 1'b0;
      ball_q   <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      period_q <= period_d;
      hold_q   <= hold_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      server_q <= server_d;
      last_q   <= last_d;
      winner_q <= winner_d;
      pt1_q    <= award && award_to == PLAYER_P1;
      pt2_q    <= award && award_to == PLAYER_P2;
      over_q   <= state_d == ST_OVER;
      ball_q   <= ball_d;
    end

  assign ball_pos_o  = ball_q;
  assign p1_score_o  = s1_q;
  assign p2_score_o  = s2_q;
  assign point_p1_o  = pt1_q;
  assign point_p2_o  = pt2_q;
  assign game_over_o = over_q;
  assign winner_o    = winner_q;
endmodule

// File: tb/tb_tennis_rally_ctrl.sv
// tb_tennis_rally_ctrl: vector table with scoreboard queue plus a timed full-rally sequence
module tb_tennis_rally_ctrl;
  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0, start_i = 1'b0, p1_hit_i = 1'b0, p2_hit_i = 1'b0;
  logic [7:0] ball_pos_o;
  logic [3:0] p1_score_o, p2_score_o;
  logic       point_p1_o, point_p2_o, game_over_o, winner_o;

  typedef struct packed {
    logic [7:0] ball;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       pt1;
    logic       pt2;
    logic       go;
    logic       win;
  } exp_t;

  typedef struct {
    int   n;
    logic r, s, a, b;
    exp_t e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0, bad = 0;

  tennis_rally_ctrl #(
    .NUM_LEDS(8), .HIT_WINDOW(2), .TICK_INIT(4), .TICK_STEP(1), .TICK_MIN(2),
    .POINT_HOLD(2), .WIN_SCORE(3), .SCORE_W(4)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .p1_hit_i(p1_hit_i), .p2_hit_i(p2_hit_i),
    .ball_pos_o(ball_pos_o), .p1_score_o(p1_score_o), .p2_score_o(p2_score_o),
    .point_p1_o(point_p1_o), .point_p2_o(point_p2_o), .game_over_o(game_over_o), .winner_o(winner_o)
  );

  always #5 clk_i = ~clk_i;

  // n clock edges; the given inputs are held only for the last edge, outputs sampled 1 time unit after it
  task automatic step(input int n, input logic r, s, a, b);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        reset_i = r; start_i = s; p1_hit_i = a; p2_hit_i = b;
      end
      @(posedge clk_i);
      #1;
      reset_i = 1'b0; start_i = 1'b0; p1_hit_i = 1'b0; p2_hit_i = 1'b0;
    end
  endtask

  task automatic v(input int n, input logic r, s, a, b, input logic [7:0] ball,
                   input int s1, s2, input logic pt1, pt2, go, win);
    vec_t x;
    x.n = n; x.r = r; x.s = s; x.a = a; x.b = b;
    x.e.ball = ball; x.e.s1 = 4'(s1); x.e.s2 = 4'(s2);
    x.e.pt1 = pt1; x.e.pt2 = pt2; x.e.go = go; x.e.win = win;
    vecs.push_back(x);
  endtask

  function automatic exp_t cur();
    exp_t g;
    g.ball = ball_pos_o; g.s1 = p1_score_o; g.s2 = p2_score_o;
    g.pt1 = point_p1_o; g.pt2 = point_p2_o; g.go = game_over_o; g.win = winner_o;
    return g;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got ball=%b s1=%0d s2=%0d pt1=%b pt2=%b go=%b win=%b, want ball=%b s1=%0d s2=%0d pt1=%b pt2=%b go=%b win=%b",
               name, got.ball, got.s1, got.s2, got.pt1, got.pt2, got.go, got.win,
               exp.ball, exp.s1, exp.s2, exp.pt1, exp.pt2, exp.go, exp.win);
    end
  endtask

  initial begin
    exp_t e;
    int   k;
    //  n   r s a b  ball    s1 s2 pt1 pt2 go win
    v(1,  1,0,0,0, 8'h00, 0,0, 0,0,0,0);
    v(1,  0,0,0,0, 8'h00, 0,0, 0,0,0,0);
    v(1,  0,0,1,0, 8'h00, 0,0, 0,0,0,0);
    v(1,  0,1,0,0, 8'h01, 0,0, 0,0,0,0);
    v(1,  0,0,0,1, 8'h01, 0,0, 0,0,0,0);
    v(1,  0,0,1,0, 8'h01, 0,0, 0,0,0,0);
    v(3,  0,0,0,0, 8'h01, 0,0, 0,0,0,0);
    v(1,  0,0,0,0, 8'h02, 0,0, 0,0,0,0);
    v(24, 0,0,0,0, 8'h80, 0,0, 0,0,0,0);
    v(3,  0,0,0,0, 8'h80, 0,0, 0,0,0,0);
    v(1,  0,0,0,0, 8'h80, 1,0, 1,0,0,0);
    v(1,  0,0,0,0, 8'h80, 1,0, 0,0,0,0);
    v(6,  0,0,1,0, 8'h80, 1,0, 0,0,0,0);
    v(1,  0,0,0,0, 8'h01, 1,0, 0,0,0,0);
    v(1,  0,0,1,0, 8'h01, 1,0, 0,0,0,0);
    v(24, 0,0,0,0, 8'h40, 1,0, 0,0,0,0);
    v(1,  0,0,0,1, 8'h40, 1,0, 0,0,0,0);
    v(2,  0,0,0,0, 8'h40, 1,0, 0,0,0,0);
    v(1,  0,0,0,0, 8'h20, 1,0, 0,0,0,0);
    v(12, 0,0,0,0, 8'h02, 1,0, 0,0,0,0);
    v(1,  0,0,1,0, 8'h02, 1,0, 0,0,0,0);
    v(1,  0,0,0,0, 8'h02, 1,0, 0,0,0,0);
    v(1,  0,0,0,0, 8'h04, 1,0, 0,0,0,0);
    v(8,  0,0,0,0, 8'h40, 1,0, 0,0,0,0);
    v(1,  0,0,0,1, 8'h40, 1,0, 0,0,0,0);
    v(1,  0,0,0,0, 8'h40, 1,0, 0,0,0,0);
    v(1,  0,0,0,0, 8'h20, 1,0, 0,0,0,0);
    v(4,  0,0,0,0, 8'h08, 1,0, 0,0,0,0);
    v(1,  0,0,1,0, 8'h08, 1,1, 0,1,0,0);
    v(3,  0,0,0,0, 8'h08, 1,1, 0,0,0,0);
    v(1,  0,0,0,0, 8'h80, 1,1, 0,0,0,0);
    v(1,  0,0,1,0, 8'h80, 1,1, 0,0,0,0);
    v(1,  0,0,0,1, 8'h80, 1,1, 0,0,0,0);
    v(16, 0,0,0,0, 8'h08, 1,1, 0,0,0,0);
    v(12, 0,0,0,0, 8'h01, 1,1, 0,0,0,0);
    v(3,  0,0,0,0, 8'h01, 1,1, 0,0,0,0);
    v(1,  0,0,1,0, 8'h01, 1,1, 0,0,0,0);
    v(3,  0,0,0,0, 8'h02, 1,1, 0,0,0,0);
    v(6,  0,0,0,0, 8'h08, 1,1, 0,0,0,0);
    v(1,  0,0,1,1, 8'h08, 2,1, 1,0,0,0);
    v(5,  0,0,0,0, 8'h08, 2,1, 0,0,0,0);
    v(1,  0,0,0,0, 8'h01, 2,1, 0,0,0,0);
    v(1,  0,0,1,0, 8'h01, 2,1, 0,0,0,0);
    v(28, 0,0,0,0, 8'h80, 2,1, 0,0,0,0);
    v(3,  0,1,0,0, 8'h80, 2,1, 0,0,0,0);
    v(1,  0,0,0,1, 8'h80, 2,1, 0,0,0,0);
    v(2,  0,0,0,0, 8'h80, 2,1, 0,0,0,0);
    v(1,  0,0,0,0, 8'h40, 2,1, 0,0,0,0);
    v(18, 0,0,0,0, 8'h01, 2,1, 0,0,0,0);
    v(3,  0,0,0,0, 8'h01, 2,2, 0,1,0,0);
    v(5,  0,0,0,0, 8'h01, 2,2, 0,0,0,0);
    v(1,  0,0,0,0, 8'h80, 2,2, 0,0,0,0);
    v(1,  0,0,0,1, 8'h80, 2,2, 0,0,0,0);
    v(24, 0,0,0,1, 8'h02, 2,2, 0,0,0,0);
    v(1,  0,0,1,0, 8'h02, 2,2, 0,0,0,0);
    v(18, 0,0,0,0, 8'h80, 2,2, 0,0,0,0);
    v(3,  0,0,0,0, 8'h80, 3,2, 1,0,0,0);
    v(5,  0,0,0,0, 8'h80, 3,2, 0,0,0,0);
    v(1,  0,0,0,0, 8'h80, 3,2, 0,0,1,0);
    v(1,  0,0,1,1, 8'h80, 3,2, 0,0,1,0);
    v(3,  0,0,0,0, 8'h80, 3,2, 0,0,1,0);
    v(1,  0,1,0,0, 8'h01, 0,0, 0,0,0,0);
    v(1,  0,0,1,0, 8'h01, 0,0, 0,0,0,0);
    v(4,  0,0,0,0, 8'h02, 0,0, 0,0,0,0);
    v(1,  0,0,0,1, 8'h02, 1,0, 1,0,0,0);
    v(7,  0,0,0,0, 8'h02, 1,0, 0,0,0,0);
    v(1,  0,0,0,0, 8'h01, 1,0, 0,0,0,0);
    v(1,  0,0,1,0, 8'h01, 1,0, 0,0,0,0);
    v(4,  0,0,0,0, 8'h02, 1,0, 0,0,0,0);
    v(1,  1,0,0,0, 8'h00, 0,0, 0,0,0,0);
    v(1,  0,0,1,0, 8'h00, 0,0, 0,0,0,0);
    v(1,  0,1,0,0, 8'h01, 0,0, 0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      sb.push_back(vecs[i].e);
      step(vecs[i].n, vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d", i), cur(), sb.pop_front());
    end

    // unreturned serve: point must land exactly 8 steps of 4 clocks after launch
    step(1, 0, 0, 1, 0);
    k = 0;
    while (!point_p1_o && k < 100) begin
      step(1, 0, 0, 0, 0);
      k++;
    end
    total++;
    if (k != 32) begin
      bad++;
      $display("FAIL miss_latency: got %0d cycles, want 32", k);
    end
    e = '{ball: 8'h80, s1: 4'd1, s2: 4'd0, pt1: 1'b1, pt2: 1'b0, go: 1'b0, win: 1'b0};
    check("miss_point", cur(), e);
    step(1, 0, 0, 0, 0);
    e.pt1 = 1'b0;
    check("miss_pulse_end", cur(), e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
